// File: rtl/seq_shift_unit.sv
// seq_shift_unit: multi-cycle LSL/LSR/ASR/ROR shifter, up to STEP bits per clock; ROR built only with SHIFT_ROR_EN.
// Latency 1+ceil(shamt/STEP) edges from accept; result held in DONE until out_ready, in_ready only in IDLE.
module seq_shift_unit #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         operand,
  input  logic [$clog2(WIDTH)-1:0] shamt,
  input  logic [1:0]               op,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         result,
  output logic                     c_out,
  output logic                     busy
);

  localparam int SHW      = $clog2(WIDTH);
  // rem never exceeds WIDTH-1, so clamping STEP there keeps k in SHW bits.
  localparam int STEP_CAP = (STEP >= WIDTH) ? WIDTH - 1 : STEP;
  localparam logic [SHW-1:0] STEP_K = SHW'(STEP_CAP);

  localparam logic [1:0] OP_LSL = 2'b00;
  localparam logic [1:0] OP_LSR = 2'b01;
  localparam logic [1:0] OP_ASR = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] val_q, val_d;
  logic [SHW-1:0]   rem_q, rem_d;
  logic [1:0]       op_q, op_d;
  logic             c_q, c_d;

  logic [SHW-1:0]   k;
  logic [SHW-1:0]   neg_k;
  logic [WIDTH-1:0] step_val;
  logic             step_c;
  logic             accept;
  logic             zero_req;

  assign accept = in_valid && (state_q == IDLE);

`ifdef SHIFT_ROR_EN
  assign zero_req = (shamt == '0);
`else
  assign zero_req = (shamt == '0) || (op == OP_ROR);
`endif

  assign k     = (rem_q < STEP_K) ? rem_q : STEP_K;
  assign neg_k = ~k + 1'b1;

  // One step of k positions; k is 1..WIDTH-1 whenever the result is used.
  always_comb begin
    step_val = val_q;
    step_c   = 1'b0;
    case (op_q)
      OP_LSL: begin
        step_val = val_q << k;
        step_c   = val_q[neg_k];
      end
      OP_LSR: begin
        step_val = val_q >> k;
        step_c   = val_q[k - 1'b1];
      end
      OP_ASR: begin
        step_val = $unsigned($signed(val_q) >>> k);
        step_c   = val_q[k - 1'b1];
      end
      default: begin
`ifdef SHIFT_ROR_EN
        step_val = (val_q >> k) | (val_q << neg_k);
        step_c   = val_q[k - 1'b1];
`endif
      end
    endcase
  end

  always_comb begin
    val_d = val_q;
    rem_d = rem_q;
    op_d  = op_q;
    c_d   = c_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          val_d = operand;
          op_d  = op;
          rem_d = zero_req ? '0 : shamt;
          c_d   = 1'b0;
        end
      end
      SHIFT: begin
        val_d = step_val;
        rem_d = rem_q - k;
        c_d   = step_c;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = zero_req ? DONE : SHIFT;
      SHIFT:   if (rem_q == k) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      val_q <= '0;
      rem_q <= '0;
      op_q  <= OP_LSL;
      c_q   <= 1'b0;
    end else begin
      val_q <= val_d;
      rem_q <= rem_d;
      op_q  <= op_d;
      c_q   <= c_d;
    end
  end

  assign result = val_q;
  assign c_out  = c_q;

endmodule

// File: tb/tb_seq_shift_unit.sv
// Scoreboard bench for seq_shift_unit: STEP=1 and STEP=4 instances, directed vectors, decoupled monitor.
`timescale 1ns/1ps
module tb_seq_shift_unit;

  localparam logic [1:0] LSL = 2'b00;
  localparam logic [1:0] LSR = 2'b01;
  localparam logic [1:0] ASR = 2'b10;
  localparam logic [1:0] ROR = 2'b11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        v0, r0, ov0, ordy0, c0, b0;
  logic [31:0] a0, res0;
  logic [4:0]  n0;
  logic [1:0]  o0;
  logic        v1, r1, ov1, ordy1, c1, b1;
  logic [31:0] a1, res1;
  logic [4:0]  n1;
  logic [1:0]  o1;

  seq_shift_unit #(.WIDTH(32), .STEP(1)) u_s1 (
    .clk(clk), .rst(rst), .in_valid(v0), .in_ready(r0), .operand(a0), .shamt(n0), .op(o0),
    .out_valid(ov0), .out_ready(ordy0), .result(res0), .c_out(c0), .busy(b0)
  );

  seq_shift_unit #(.WIDTH(32), .STEP(4)) u_s4 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(r1), .operand(a1), .shamt(n1), .op(o1),
    .out_valid(ov1), .out_ready(ordy1), .result(res1), .c_out(c1), .busy(b1)
  );

  typedef struct {
    logic [31:0] res;
    logic        c;
    int          lat;
    int          acc;
    int          id;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  logic pv0         = 1'b0;
  logic pv1         = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s #%0d: got 0x%08h, need 0x%08h", name, id, act, req);
    end
  endtask

  task automatic mon_pop(input int d, input logic [31:0] r, input logic c);
    exp_t e;
    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
      vectors++;
      miscompares++;
      $display("FAIL unexpected_out dut%0d: got result 0x%08h, need no output", d, r);
      return;
    end
    if (d == 0) e = q0.pop_front();
    else        e = q1.pop_front();
    chk("result", e.id, r, e.res);
    chk("c_out", e.id, {31'b0, c}, {31'b0, e.c});
    chk("latency", e.id, 32'(cyc - e.acc + 1), 32'(e.lat));
  endtask

  // Monitor: compares on each rising out_valid, independent of the driver.
  initial begin
    forever begin
      @(negedge clk);
      if (ov0 && !pv0) mon_pop(0, res0, c0);
      if (ov1 && !pv1) mon_pop(1, res1, c1);
      pv0 = ov0;
      pv1 = ov1;
    end
  end

  task automatic issue(input int d, input int id, input logic [1:0] o, input logic [31:0] a,
                       input logic [4:0] n, input logic [31:0] er, input logic ec,
                       input int el, input bit push);
    int   t = 0;
    exp_t e;
    while (((d == 0) ? r0 : r1) !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      vectors++;
      miscompares++;
      $display("FAIL in_ready_timeout #%0d: got 0, need 1", id);
      return;
    end
    if (d == 0) begin v0 = 1'b1; a0 = a; n0 = n; o0 = o; end
    else        begin v1 = 1'b1; a1 = a; n1 = n; o1 = o; end
    e.res = er; e.c = ec; e.lat = el; e.acc = cyc + 1; e.id = id;
    if (push) begin
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
    @(negedge clk);
    // Scramble inputs after accept; the unit must ignore them.
    if (d == 0) begin v0 = 1'b0; a0 = ~a; n0 = ~n; o0 = ~o; end
    else        begin v1 = 1'b0; a1 = ~a; n1 = ~n; o1 = ~o; end
  endtask

  task automatic drain();
    int t = 0;
    while ((q0.size() != 0 || q1.size() != 0) && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: got %0d outstanding, need 0", q0.size() + q1.size());
    end
  endtask

  initial begin
    int t;
    rst = 1'b1;
    v0 = 1'b0; a0 = '0; n0 = '0; o0 = '0; ordy0 = 1'b1;
    v1 = 1'b0; a1 = '0; n1 = '0; o1 = '0; ordy1 = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("rst_in_ready0", 0, r0, 1);
    chk("rst_out_valid0", 0, ov0, 0);
    chk("rst_result0", 0, res0, 0);
    chk("rst_c_out0", 0, c0, 0);
    chk("rst_busy0", 0, b0, 0);
    chk("rst_in_ready1", 0, r1, 1);
    chk("rst_result1", 0, res1, 0);

    // STEP=1
    issue(0, 1, ASR, 32'h800000F0, 5'd4,  32'hF800000F, 1'b0, 5,  1);
    issue(0, 2, LSR, 32'h80000001, 5'd1,  32'h40000000, 1'b1, 2,  1);
    issue(0, 3, LSL, 32'hC0000000, 5'd1,  32'h80000000, 1'b1, 2,  1);
    issue(0, 4, LSL, 32'h12345678, 5'd0,  32'h12345678, 1'b0, 1,  1);
`ifdef SHIFT_ROR_EN
    issue(0, 5, ROR, 32'h00000001, 5'd1,  32'h80000000, 1'b1, 2,  1);
    issue(0, 6, ROR, 32'h12345678, 5'd8,  32'h78123456, 1'b0, 9,  1);
`else
    issue(0, 5, ROR, 32'h00000001, 5'd1,  32'h00000001, 1'b0, 1,  1);
    issue(0, 6, ROR, 32'h12345678, 5'd8,  32'h12345678, 1'b0, 1,  1);
`endif
    issue(0, 7, LSL, 32'h00000001, 5'd31, 32'h80000000, 1'b0, 32, 1);
    issue(0, 8, LSR, 32'hFFFFFFFF, 5'd31, 32'h00000001, 1'b1, 32, 1);
    issue(0, 9, ASR, 32'h7FFFFFFF, 5'd31, 32'h00000000, 1'b1, 32, 1);
    drain();

    // STEP=4
    issue(1, 10, ASR, 32'hF0000000, 5'd31, 32'hFFFFFFFF, 1'b1, 9, 1);
    issue(1, 11, LSR, 32'h000000FF, 5'd6,  32'h00000003, 1'b1, 3, 1);
    issue(1, 12, LSL, 32'h0000000F, 5'd5,  32'h000001E0, 1'b0, 3, 1);
    issue(1, 13, LSR, 32'h80000000, 5'd4,  32'h08000000, 1'b0, 2, 1);
`ifdef SHIFT_ROR_EN
    issue(1, 14, ROR, 32'h000000F0, 5'd5,  32'h80000007, 1'b1, 3, 1);
`else
    issue(1, 14, ROR, 32'h000000F0, 5'd5,  32'h000000F0, 1'b0, 1, 1);
`endif
    drain();

    // Backpressure: hold DONE for 10 cycles.
    ordy0 = 1'b0;
    issue(0, 20, LSR, 32'h0000F000, 5'd4, 32'h00000F00, 1'b0, 5, 1);
    t = 0;
    while (ov0 !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      vectors++;
      miscompares++;
      $display("FAIL out_valid_timeout #20: got 0, need 1");
    end
    repeat (10) begin
      @(negedge clk);
      chk("hold_out_valid", 20, ov0, 1);
      chk("hold_result", 20, res0, 32'h00000F00);
      chk("hold_in_ready", 20, r0, 0);
    end
    ordy0 = 1'b1;
    @(negedge clk);
    chk("drop_out_valid", 20, ov0, 0);
    chk("idle_result_kept", 20, res0, 32'h00000F00);
    chk("idle_in_ready", 20, r0, 1);

    // Reset in the middle of a shift drops the request.
    issue(0, 21, LSL, 32'hFFFFFFFF, 5'd20, 32'h0, 1'b0, 0, 0);
    repeat (2) @(negedge clk);
    chk("shift_busy", 21, b0, 1);
    chk("shift_in_ready", 21, r0, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_in_ready", 21, r0, 1);
    chk("midrst_out_valid", 21, ov0, 0);
    chk("midrst_result", 21, res0, 0);
    chk("midrst_busy", 21, b0, 0);
    chk("midrst_c_out", 21, c0, 0);
    repeat (30) @(negedge clk);

    issue(0, 22, LSR, 32'h80000001, 5'd1, 32'h40000000, 1'b1, 2, 1);
    drain();
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
